// File: rtl/glyph_rain_if.sv
// Video timing, control and glyph-ROM signals between the sync generator side and the rain engine.
interface glyph_rain_if;
  logic [9:0] hpos;
  logic [9:0] vpos;
  logic       display_on;
  logic       hsync_in;
  logic       vsync_in;
  logic [1:0] palette_sel;
  logic       freeze;
  logic [5:0] glyph_c;
  logic [3:0] glyph_y;
  logic [2:0] glyph_x;
  logic       glyph_pixel;
  logic [5:0] rgb;
  logic       hsync_out;
  logic       vsync_out;
  logic       busy;
  logic [9:0] frame;

  modport master (
    output hpos, vpos, display_on, hsync_in, vsync_in, palette_sel, freeze, glyph_pixel,
    input  glyph_c, glyph_y, glyph_x, rgb, hsync_out, vsync_out, busy, frame
  );

  modport slave (
    input  hpos, vpos, display_on, hsync_in, vsync_in, palette_sel, freeze, glyph_pixel,
    output glyph_c, glyph_y, glyph_x, rgb, hsync_out, vsync_out, busy, frame
  );
endinterface

// File: rtl/glyph_rain_engine.sv
// Glyph-rain pixel engine: per-column drop state swept once per frame in vblank,
// two-stage pixel pipeline (cell/ROM lookup, then intensity and palette).
module glyph_rain_engine #(
  parameter int unsigned NCOLS        = 80,
  parameter int unsigned NROWS        = 40,
  parameter int unsigned GLYPH_W_LOG2 = 3,
  parameter int unsigned GLYPH_H      = 12,
  parameter int unsigned TRAIL_LEN    = 16,
  parameter int unsigned NGLYPHS      = 51,
  parameter int unsigned H_TOTAL      = 800,
  parameter int unsigned V_TOTAL      = 525,
  parameter int unsigned HEAD_W       = 7,
  parameter logic [15:0] SEED         = 16'hACE1
) (
  input logic         clk,
  input logic         rst_n,
  glyph_rain_if.slave vid
);

  localparam int unsigned ColW     = $clog2(NCOLS);
  localparam int unsigned HposColW = 10 - GLYPH_W_LOG2;
  localparam int unsigned RowW     = $clog2((V_TOTAL + GLYPH_H - 1) / GLYPH_H);
  localparam int unsigned DistW    = HEAD_W + 1;
  localparam logic [DistW-1:0] HeadLimit = DistW'(NROWS + TRAIL_LEN);
  localparam logic [DistW-1:0] TrailLim  = DistW'(TRAIL_LEN);

  typedef enum logic {StIdle, StSweep} state_e;

  state_e                 state_q, state_d;
  logic [9:0]             frame_q, frame_d;
  logic [ColW-1:0]        col_idx_q, col_idx_d;
  logic                   seeded_q, seeded_d;
  logic [15:0]            lfsr_q, lfsr_d, lfsr_step;
  logic                   vs_prev_q;
  logic                   frame_start;

  logic [HEAD_W-1:0]      head_q [NCOLS];
  logic [NCOLS-1:0]       speed_q;
  logic                   head_we;
  logic [HEAD_W-1:0]      head_wdata;
  logic                   speed_wdata;
  logic [HEAD_W-1:0]      cur_head;
  logic                   cur_speed;
  logic [DistW-1:0]       head_sum;

  logic [RowW-1:0]        row_q, row_d;
  logic [3:0]             sub_q, sub_d;

  // Cell counters advance at end of line so they describe the next line at hpos=0.
  always_comb begin
    row_d = row_q;
    sub_d = sub_q;
    if (vid.hpos == 10'(H_TOTAL - 1)) begin
      if (vid.vpos == 10'(V_TOTAL - 1)) begin
        row_d = '0;
        sub_d = '0;
      end else if (sub_q == 4'(GLYPH_H - 1)) begin
        sub_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        sub_d = sub_q + 1'b1;
      end
    end
  end

  assign frame_start = vs_prev_q & ~vid.vsync_in;
  assign lfsr_step   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  assign cur_head    = head_q[col_idx_q];
  assign cur_speed   = speed_q[col_idx_q];
  assign head_sum    = {1'b0, cur_head} + DistW'(1) + DistW'(cur_speed);

  always_comb begin
    state_d     = state_q;
    frame_d     = frame_q;
    col_idx_d   = col_idx_q;
    seeded_d    = seeded_q;
    lfsr_d      = lfsr_q;
    head_we     = 1'b0;
    head_wdata  = cur_head;
    speed_wdata = cur_speed;
    unique case (state_q)
      StIdle: begin
        if (frame_start) begin
          state_d   = StSweep;
          col_idx_d = '0;
          if (!vid.freeze) frame_d = frame_q + 10'd1;
        end
      end
      StSweep: begin
        lfsr_d = lfsr_step;
        if (!seeded_q) begin
          head_we     = 1'b1;
          head_wdata  = ({1'b0, lfsr_step[HEAD_W-1:0]} < HeadLimit) ? lfsr_step[HEAD_W-1:0] : '0;
          speed_wdata = lfsr_step[8];
        end else if (!vid.freeze) begin
          head_we = 1'b1;
          if (head_sum >= HeadLimit) begin
            head_wdata  = '0;
            speed_wdata = lfsr_step[8];
          end else begin
            head_wdata = head_sum[HEAD_W-1:0];
          end
        end
        if (col_idx_q == ColW'(NCOLS - 1)) begin
          state_d  = StIdle;
          seeded_d = 1'b1;
        end else begin
          col_idx_d = col_idx_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      frame_q   <= '0;
      col_idx_q <= '0;
      seeded_q  <= 1'b0;
      lfsr_q    <= SEED;
      vs_prev_q <= 1'b1;
      row_q     <= '0;
      sub_q     <= '0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      col_idx_q <= col_idx_d;
      seeded_q  <= seeded_d;
      lfsr_q    <= lfsr_d;
      vs_prev_q <= vid.vsync_in;
      row_q     <= row_d;
      sub_q     <= sub_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCOLS; i++) head_q[i] <= '0;
      speed_q <= '0;
    end else if (head_we) begin
      head_q[col_idx_q]  <= head_wdata;
      speed_q[col_idx_q] <= speed_wdata;
    end
  end

  // Stage 1: cell lookup.
  logic [HposColW-1:0]     hpos_col;
  logic                    col_valid;
  logic [ColW-1:0]         rd_idx;
  logic [DistW-1:0]        dist_d;

  assign hpos_col  = vid.hpos[9:GLYPH_W_LOG2];
  assign col_valid = ({{(32 - HposColW){1'b0}}, hpos_col} < NCOLS);
  assign rd_idx    = col_valid ? ColW'(hpos_col) : '0;
  assign dist_d    = {1'b0, head_q[rd_idx]} - DistW'(row_q);

  logic [5:0]              s1_col_q;
  logic                    s1_valid_q;
  logic [RowW-1:0]         s1_row_q;
  logic [3:0]              s1_sub_q;
  logic [GLYPH_W_LOG2-1:0] s1_x_q;
  logic                    s1_de_q;
  logic                    s1_hs_q;
  logic                    s1_vs_q;
  logic [1:0]              s1_pal_q;
  logic [DistW-1:0]        s1_dist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_col_q   <= '0;
      s1_valid_q <= 1'b0;
      s1_row_q   <= '0;
      s1_sub_q   <= '0;
      s1_x_q     <= '0;
      s1_de_q    <= 1'b0;
      s1_hs_q    <= 1'b1;
      s1_vs_q    <= 1'b1;
      s1_pal_q   <= '0;
      s1_dist_q  <= '0;
    end else begin
      s1_col_q   <= hpos_col[5:0];
      s1_valid_q <= col_valid;
      s1_row_q   <= row_q;
      s1_sub_q   <= sub_q;
      s1_x_q     <= vid.hpos[GLYPH_W_LOG2-1:0];
      s1_de_q    <= vid.display_on;
      s1_hs_q    <= vid.hsync_in;
      s1_vs_q    <= vid.vsync_in;
      s1_pal_q   <= vid.palette_sel;
      s1_dist_q  <= dist_d;
    end
  end

  // Glyph hash scrolls with frame[9:4] so the characters slowly change.
  logic [5:0] glyph_h;
  logic [5:0] row3;
  assign row3    = 6'(s1_row_q) + {s1_row_q[4:0], 1'b0};
  assign glyph_h = s1_col_q + row3 + frame_q[9:4];

  assign vid.glyph_c = ({1'b0, glyph_h} >= 7'(NGLYPHS)) ? 6'({1'b0, glyph_h} - 7'(NGLYPHS))
                                                      : glyph_h;
  assign vid.glyph_y = s1_sub_q;
  assign vid.glyph_x = 3'(s1_x_q);

  // Stage 2: intensity and palette; dist is non-negative when the sign bit is clear.
  logic       lit;
  logic [1:0] level;
  logic [5:0] colour;

  assign lit = s1_valid_q && !s1_dist_q[DistW-1] && (s1_dist_q < TrailLim);

  always_comb begin
    level = 2'd1;
    if (s1_dist_q <= DistW'(3))      level = 2'd3;
    else if (s1_dist_q <= DistW'(7)) level = 2'd2;
    colour = '0;
    if (s1_dist_q == '0) begin
      colour = 6'b111111;
    end else begin
      unique case (s1_pal_q)
        2'd0: colour = {2'b00, level, 2'b00};
        2'd1: colour = {level, 1'b0, level[1], 2'b00};
        2'd2: colour = {2'b00, level, level};
        2'd3: colour = {level, level, level};
        default: colour = '0;
      endcase
    end
  end

  logic [5:0] rgb_q;
  logic       hs_out_q;
  logic       vs_out_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q    <= '0;
      hs_out_q <= 1'b1;
      vs_out_q <= 1'b1;
    end else begin
      rgb_q    <= (s1_de_q && vid.glyph_pixel && lit) ? colour : 6'd0;
      hs_out_q <= s1_hs_q;
      vs_out_q <= s1_vs_q;
    end
  end

  assign vid.rgb       = rgb_q;
  assign vid.hsync_out = hs_out_q;
  assign vid.vsync_out = vs_out_q;
  assign vid.busy      = (state_q == StSweep);
  assign vid.frame     = frame_q;

endmodule

// File: tb/tb_glyph_rain_engine.sv
// Self-checking bench for glyph_rain_engine: fixed pixel vectors, sweep/motion model, random pixels.
module tb_glyph_rain_engine;

  localparam int NC = 80;
  localparam int LIM = 56;   // NROWS + TRAIL_LEN

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  glyph_rain_if vif ();

  glyph_rain_engine dut (
    .clk   (clk),
    .rst_n (rst_n),
    .vid   (vif)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state
  int        m_head [NC];
  int        m_speed[NC];
  bit [15:0] m_lfsr;
  bit        m_seeded;
  int        m_frame;
  int        m_row, m_sub;

  typedef struct {
    bit [9:0] hpos;
    bit       de;
    bit       px;
    bit [1:0] pal;
    bit       hs;
    bit [5:0] exp_c;
    bit [2:0] exp_x;
    bit [5:0] exp_rgb;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_reset();
    for (int c = 0; c < NC; c++) begin
      m_head[c]  = 0;
      m_speed[c] = 0;
    end
    m_lfsr   = 16'hACE1;
    m_seeded = 0;
    m_frame  = 0;
    m_row    = 0;
    m_sub    = 0;
  endfunction

  function automatic bit [15:0] lfsr_next(input bit [15:0] x);
    bit [15:0] y;
    y = x >> 1;
    if (x[0]) y = y ^ 16'hB400;
    return y;
  endfunction

  function automatic void model_sweep(input bit frz);
    int h;
    if (!frz) m_frame = (m_frame + 1) % 1024;
    for (int c = 0; c < NC; c++) begin
      m_lfsr = lfsr_next(m_lfsr);
      if (!m_seeded) begin
        h = m_lfsr % 128;
        m_head[c]  = (h < LIM) ? h : 0;
        m_speed[c] = m_lfsr[8];
      end else if (!frz) begin
        h = m_head[c] + 1 + m_speed[c];
        if (h >= LIM) begin
          m_head[c]  = 0;
          m_speed[c] = m_lfsr[8];
        end else begin
          m_head[c] = h;
        end
      end
    end
    m_seeded = 1;
  endfunction

  function automatic void model_line(input int v);
    if (v == 524) begin
      m_row = 0;
      m_sub = 0;
    end else if (m_sub == 11) begin
      m_sub = 0;
      m_row++;
    end else begin
      m_sub++;
    end
  endfunction

  function automatic int exp_glyph_c(input int hp);
    int h;
    h = ((hp / 8) % 64 + 3 * m_row + m_frame / 16) % 64;
    return (h >= 51) ? h - 51 : h;
  endfunction

  function automatic bit [5:0] exp_rgb(input int hp, input bit de, input bit px, input int pal);
    int col, d;
    bit [1:0] lv;
    col = hp / 8;
    if (!de || !px || col >= NC) return 6'd0;
    d = m_head[col] - m_row;
    if (d < 0 || d >= 16) return 6'd0;
    if (d == 0) return 6'b111111;
    lv = (d <= 3) ? 2'd3 : (d <= 7) ? 2'd2 : 2'd1;
    case (pal)
      0:       return {2'b00, lv, 2'b00};
      1:       return {lv, 1'b0, lv[1], 2'b00};
      2:       return {2'b00, lv, lv};
      default: return {lv, lv, lv};
    endcase
  endfunction

  task automatic compare_heads(input string tag);
    int hm, sm;
    hm = 0;
    sm = 0;
    for (int c = 0; c < NC; c++) begin
      if (int'(dut.head_q[c]) != m_head[c]) hm++;
      if (int'(dut.speed_q[c]) != m_speed[c]) sm++;
    end
    check({tag, "_head_mismatches"}, hm, 0);
    check({tag, "_speed_mismatches"}, sm, 0);
  endtask

  task automatic step_line(input int v);
    vif.hpos       = 10'd799;
    vif.vpos       = 10'(v);
    vif.display_on = 1'b0;
    tick();
    model_line(v);
    vif.hpos = 10'd0;
    vif.vpos = 10'd100;
  endtask

  task automatic apply_pixel(input string tag, input int hp, input bit de, input bit px,
                             input int pal, input bit hs, input int ec, input int ey,
                             input int ex, input int ergb);
    vif.hpos        = 10'(hp);
    vif.vpos        = 10'd100;
    vif.display_on  = de;
    vif.glyph_pixel = px;
    vif.palette_sel = 2'(pal);
    vif.hsync_in    = hs;
    tick();
    check({tag, "_glyph_c"}, vif.glyph_c, ec);
    check({tag, "_glyph_y"}, vif.glyph_y, ey);
    check({tag, "_glyph_x"}, vif.glyph_x, ex);
    tick();
    check({tag, "_rgb"}, vif.rgb, ergb);
    check({tag, "_hsync_out"}, vif.hsync_out, hs);
    vif.hsync_in   = 1'b1;
    vif.display_on = 1'b0;
  endtask

  task automatic run_frame(input string tag, input bit frz, input bit glitch);
    int wait_n, busy_n;
    vif.freeze   = frz;
    vif.vsync_in = 1'b1;
    tick();
    vif.vsync_in = 1'b0;
    tick();
    check({tag, "_vsync_out_d1"}, vif.vsync_out, 1);
    wait_n = 0;
    while (!vif.busy && wait_n < 10) begin
      tick();
      wait_n++;
    end
    busy_n = 0;
    while (vif.busy && busy_n < 200) begin
      busy_n++;
      if (glitch && busy_n == 20) vif.vsync_in = 1'b1;
      if (glitch && busy_n == 21) vif.vsync_in = 1'b0;
      tick();
    end
    check({tag, "_vsync_out_low"}, vif.vsync_out, 0);
    vif.vsync_in = 1'b1;
    model_sweep(frz);
    check({tag, "_busy_cycles"}, busy_n, NC);
    check({tag, "_frame"}, vif.frame, m_frame);
    compare_heads(tag);
    tick();
    vif.freeze = 1'b0;
  endtask

  initial begin
    vif.hpos = 10'd0;  vif.vpos = 10'd0;  vif.display_on = 1'b0;
    vif.hsync_in = 1'b1; vif.vsync_in = 1'b1; vif.palette_sel = 2'd0;
    vif.freeze = 1'b0; vif.glyph_pixel = 1'b0;

    // hpos, de, px, pal, hs, glyph_c, glyph_x, rgb  (reset state: heads 0, row 0, frame 0)
    vecs[0]  = '{10'd0,   1, 1, 2'd0, 1, 6'd0,  3'd0, 6'h3f};
    vecs[1]  = '{10'd7,   1, 1, 2'd1, 0, 6'd0,  3'd7, 6'h3f};
    vecs[2]  = '{10'd12,  1, 1, 2'd2, 1, 6'd1,  3'd4, 6'h3f};
    vecs[3]  = '{10'd440, 1, 1, 2'd3, 1, 6'd4,  3'd0, 6'h3f};
    vecs[4]  = '{10'd509, 1, 1, 2'd0, 0, 6'd12, 3'd5, 6'h3f};
    vecs[5]  = '{10'd512, 1, 1, 2'd0, 1, 6'd0,  3'd0, 6'h3f};
    vecs[6]  = '{10'd634, 1, 1, 2'd0, 1, 6'd15, 3'd2, 6'h3f};
    vecs[7]  = '{10'd640, 1, 1, 2'd0, 1, 6'd16, 3'd0, 6'h00};
    vecs[8]  = '{10'd700, 1, 1, 2'd0, 0, 6'd23, 3'd4, 6'h00};
    vecs[9]  = '{10'd100, 0, 1, 2'd0, 1, 6'd12, 3'd4, 6'h00};
    vecs[10] = '{10'd100, 1, 0, 2'd0, 1, 6'd12, 3'd4, 6'h00};
    vecs[11] = '{10'd408, 1, 1, 2'd0, 1, 6'd0,  3'd0, 6'h3f};
    vecs[12] = '{10'd407, 1, 1, 2'd0, 1, 6'd50, 3'd7, 6'h3f};

    // Power-on reset
    #2 rst_n = 1'b0;
    #1;
    check("por_rgb", vif.rgb, 0);
    check("por_busy", vif.busy, 0);
    check("por_frame", vif.frame, 0);
    check("por_hsync_out", vif.hsync_out, 1);
    check("por_vsync_out", vif.vsync_out, 1);
    repeat (3) tick();
    #2 rst_n = 1'b1;
    model_reset();
    tick();

    for (int i = 0; i < 13; i++) begin
      apply_pixel($sformatf("vec%0d", i), vecs[i].hpos, vecs[i].de, vecs[i].px, vecs[i].pal,
                  vecs[i].hs, vecs[i].exp_c, 0, vecs[i].exp_x, vecs[i].exp_rgb);
    end

    // Sync pass-through latency is exactly two clocks
    vif.hsync_in = 1'b0;
    tick();
    check("hsync_lat1", vif.hsync_out, 1);
    tick();
    check("hsync_lat2", vif.hsync_out, 0);
    vif.hsync_in = 1'b1;
    tick();
    tick();

    // Cell counter boundaries: sub 11 -> 0 with row 0 -> 1, then last line clears both
    for (int v = 0; v < 11; v++) step_line(v);
    apply_pixel("sub11", 0, 1, 1, 0, 1, 0, 11, 0, 6'h3f);
    step_line(11);
    apply_pixel("row1", 0, 1, 1, 0, 1, 3, 0, 0, 0);
    step_line(100);
    apply_pixel("row1_sub1", 9, 1, 1, 0, 1, 4, 1, 1, 0);
    step_line(524);
    apply_pixel("vwrap", 0, 1, 1, 0, 1, 0, 0, 0, 6'h3f);

    // Seeding sweep, motion frames (one with an ignored re-trigger), freeze, resume
    run_frame("seed", 1'b0, 1'b0);
    for (int f = 0; f < 12; f++) run_frame($sformatf("move%0d", f), 1'b0, f == 3);
    for (int f = 0; f < 3; f++) run_frame($sformatf("frz%0d", f), 1'b1, 1'b0);
    for (int f = 0; f < 20; f++) run_frame($sformatf("resume%0d", f), 1'b0, 1'b0);

    // Random pixels against the model
    for (int it = 0; it < 300; it++) begin
      int nl, hp, pal;
      bit de, px, hs;
      nl = $urandom_range(0, 14);
      for (int k = 0; k < nl; k++) step_line((m_row >= 40) ? 524 : $urandom_range(0, 523));
      hp  = $urandom_range(0, 798);
      de  = ($urandom_range(0, 7) != 0);
      px  = ($urandom_range(0, 3) != 0);
      pal = $urandom_range(0, 3);
      hs  = $urandom_range(0, 1);
      apply_pixel("rnd", hp, de, px, pal, hs, exp_glyph_c(hp), m_sub, hp % 8,
                  exp_rgb(hp, de, px, pal));
    end

    // Reset in the middle of a sweep
    vif.hsync_in = 1'b0;
    vif.vsync_in = 1'b0;
    repeat (30) tick();
    check("mid_busy_before", vif.busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", vif.busy, 0);
    check("mid_rst_frame", vif.frame, 0);
    check("mid_rst_rgb", vif.rgb, 0);
    check("mid_rst_hsync_out", vif.hsync_out, 1);
    check("mid_rst_vsync_out", vif.vsync_out, 1);
    model_reset();
    compare_heads("mid_rst");
    vif.hsync_in = 1'b1;
    vif.vsync_in = 1'b1;
    tick();
    #2 rst_n = 1'b1;
    tick();
    run_frame("reseed", 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
